uart_rx_buffer: RTL and testbench
=================================

# uart_rx_buffer

Receive-side buffer and flow controller between `uart_rx` and the byte consumer (command parser / host logic). Captures each byte `uart_rx` reports, queues it in a first-word-fall-through FIFO, and drops and counts bytes flagged with parity or framing errors. Tracks overflow and, optionally, signals line idle after a configurable gap so the consumer can delimit packets.

## Interface
- `DEPTH`, 16, FIFO entries; power of two, 2..256
- `TIMEOUT_CYCLES`, 34720, idle gap in clk cycles before `idle` pulses; 40 bit-times at 115200 baud on 100 MHz
- `clk`  in  1  system clock, 100 MHz
- `rst_n`  in  1  reset; one clock, synchronous, active-low
- `rx_ready`  in  1  one-cycle strobe from `uart_rx`: `rx_val` holds a completed frame
- `rx_error`  in  1  one-cycle strobe from `uart_rx`: parity/stop error on the current frame
- `rx_val`  in  8  received byte
- `out_valid`  out  1  FIFO non-empty
- `out_ready`  in  1  consumer accepts `out_data` this cycle
- `out_data`  out  8  head byte, valid while `out_valid`
- `count`  out  $clog2(DEPTH)+1  current occupancy
- `overflow`  out  1  sticky: a good byte was dropped because the FIFO was full
- `err_cnt`  out  8  saturating count of error frames
- `clear`  in  1  clears `overflow` and `err_cnt`
- `flush`  in  1  empties the FIFO
- `idle`  out  1  one-cycle pulse on idle timeout (0 when macro absent)

## Operation
- Push: on `rx_ready && !rx_error` with FIFO not full, write `rx_val` at `wr_ptr`, increment `wr_ptr`.
- Error frame: any cycle with `rx_error`=1 increments `err_cnt`, saturating at 255. Simultaneous `rx_ready` with `rx_error` drops the byte; it is not pushed.
- Pop: on `out_valid && out_ready`, increment `rd_ptr`. `out_ready` while empty has no effect.
- Full: push while `count==DEPTH` and no pop this cycle drops the byte and sets `overflow`. Push and pop in the same cycle when full: both proceed, `count` stays DEPTH, no overflow.
- Push and pop in the same cycle at any other occupancy: `count` unchanged, both pointers advance.
- Empty: `out_valid`=0. `out_data` is undefined and need not be held.
- Pointers are `$clog2(DEPTH)` bits and wrap modulo DEPTH. Full/empty are derived from `count`.
- `flush`: `rd_ptr`←`wr_ptr` and `count`←0 next cycle. A push in the same cycle is discarded. Flush does not clear `overflow` or `err_cnt`.
- `clear`: `overflow`←0, `err_cnt`←0. If `clear` coincides with a new overflow or error event, the event wins: `overflow`=1, `err_cnt`=1.
- Reset: pointers, `count`, `overflow`, `err_cnt`, the timeout counter and timeout state all go to 0. Outputs after reset: `out_valid`=0, `count`=0, `overflow`=0, `err_cnt`=0, `idle`=0. Reset in the middle of a burst loses all queued data.

## Timing
- Push strobe in cycle N → `out_valid`=1 and `out_data`=byte in cycle N+1. FIFO memory reads are asynchronous from `rd_ptr`.
- Pop in cycle N → next entry on `out_data` in cycle N+1. Sustained throughput is one byte per clock in each direction.
- `count`, `overflow` and `err_cnt` update in the cycle after the causing event.
- `uart_rx` strobes arrive at most once per ~9550 cycles (11-bit frame). The block still handles back-to-back strobes.

## Configuration
- `UART_RX_IDLE_TIMEOUT_EN` defined: two-state FSM.
  - WAIT: counter held at 0; waiting for the first byte.
  - ARMED: entered on any `rx_ready` or `rx_error`. The counter is cleared on every such strobe and increments otherwise.
  - When the counter reaches `TIMEOUT_CYCLES-1`, `idle` pulses for one cycle and the FSM returns to WAIT.
  - `flush` forces WAIT.
  - Exactly one `idle` pulse per burst.
- `UART_RX_IDLE_TIMEOUT_EN` undefined: no counter or FSM logic; `idle` is tied to 0.

## Test plan
- Reset, then three frames of 0x95 (8680 ns/bit, even parity OK), `out_ready`=0 → `count`=3, `out_data`=0x95, `err_cnt`=0. Assert `out_ready` → three pops, then `out_valid`=0.
- `rx_ready` strobe together with `rx_error`, `rx_val`=0x3C → `count` unchanged, `err_cnt`=1. 300 error strobes → `err_cnt`=255. Then `clear` → `err_cnt`=0.
- Push 0x00..0x10 (17 bytes) with `DEPTH`=16, no pops → `count`=16, `overflow`=1. Pops read 0x00..0x0F in order; 0x10 is lost.
- Fill to 16, then push 0xAA with a pop in the same cycle → `count`=16, `overflow`=0; 0xAA read last. Pointer wrap checked over 40 push/pop pairs with incrementing data.
- Push 5 bytes, then `flush` in the same cycle as a push of 0x77 → `count`=0 and `out_valid`=0 next cycle; 0x77 is not stored.
- With `UART_RX_IDLE_TIMEOUT_EN`, `TIMEOUT_CYCLES`=1000: byte at cycle T → single `idle` pulse at T+1000. A second byte at T+500 → pulse moves to T+1500. No pulse after reset without traffic.

Source files
------------

// File: rtl/uart_rx_buffer_if.sv
// Byte stream interface between uart_rx, the receive buffer and the byte consumer.
// The slave side is the buffer; the master side is its environment (receiver plus consumer).
interface uart_rx_buffer_if;
    logic       rx_ready;   // strobe: rx_val holds a completed frame
    logic       rx_error;   // strobe: parity/stop error on the current frame
    logic [7:0] rx_val;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;

    modport master (
        output rx_ready,
        output rx_error,
        output rx_val,
        output out_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  rx_ready,
        input  rx_error,
        input  rx_val,
        input  out_ready,
        output out_valid,
        output out_data
    );
endinterface

// File: rtl/uart_rx_buffer.sv
// Receive-side buffer: first-word-fall-through FIFO for bytes from uart_rx, dropping and
// counting error frames, with a sticky overflow flag.
// Optional feature macro UART_RX_IDLE_TIMEOUT_EN adds an idle-gap detector that pulses idle_o
// once per burst; without it idle_o is tied low.
module uart_rx_buffer #(
    parameter int unsigned DEPTH          = 16,
    parameter int unsigned TIMEOUT_CYCLES = 34720
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    uart_rx_buffer_if.slave          bus,
    input  logic                     clear_i,
    input  logic                     flush_i,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o,
    output logic [7:0]               err_cnt_o,
    output logic                     idle_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FullCount = CW'(DEPTH);

    if (DEPTH < 2 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_rx_buffer: DEPTH must be a power of two in 2..256");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("uart_rx_buffer: TIMEOUT_CYCLES must be at least 2");
    end

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic [7:0]    err_cnt_q, err_cnt_d;
    logic          push_req, push, pop, full, ovf_set;

    // FIFO pointer/occupancy next state; flush overrides any push or pop.
    always_comb begin
        full     = (count_q == FullCount);
        pop      = (count_q != '0) && bus.out_ready;
        push_req = bus.rx_ready && !bus.rx_error && !flush_i;
        // A pop frees the slot in the same cycle, so a full FIFO still accepts the byte.
        push     = push_req && (!full || pop);
        ovf_set  = push_req && full && !pop;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    // Status flags; a new event beats a coincident clear.
    always_comb begin
        overflow_d = overflow_q;
        err_cnt_d  = err_cnt_q;
        if (ovf_set) begin
            overflow_d = 1'b1;
        end else if (clear_i) begin
            overflow_d = 1'b0;
        end
        if (bus.rx_error) begin
            if (clear_i) begin
                err_cnt_d = 8'd1;
            end else if (err_cnt_q != 8'hFF) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
        end else if (clear_i) begin
            err_cnt_d = 8'd0;
        end
    end

    // Control state with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            err_cnt_q  <= 8'd0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    // Storage array; contents need no reset since occupancy gates visibility.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.rx_val;
        end
    end

    assign bus.out_valid = (count_q != '0);
    assign bus.out_data  = mem_q[rd_ptr_q];
    assign count_o       = count_q;
    assign overflow_o    = overflow_q;
    assign err_cnt_o     = err_cnt_q;

`ifdef UART_RX_IDLE_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TimeoutLast = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [0:0] StWait  = 1'b0;
    localparam logic [0:0] StArmed = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic          strobe, idle;

    // Idle detector: armed by any receiver strobe, fires once after a quiet gap.
    always_comb begin
        strobe  = bus.rx_ready || bus.rx_error;
        state_d = state_q;
        tmr_d   = tmr_q;
        idle    = 1'b0;
        if (flush_i) begin
            state_d = StWait;
            tmr_d   = '0;
        end else if (strobe) begin
            state_d = StArmed;
            tmr_d   = '0;
        end else if (state_q == StArmed) begin
            if (tmr_q == TimeoutLast) begin
                idle    = 1'b1;
                state_d = StWait;
                tmr_d   = '0;
            end else begin
                tmr_d = tmr_q + TW'(1);
            end
        end
    end

    // Idle detector state with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StWait;
            tmr_q   <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
        end
    end

    assign idle_o = idle;
`else
    assign idle_o = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_buffer.sv
// Self-checking bench for uart_rx_buffer: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_uart_rx_buffer;
    localparam int unsigned DEPTH   = 16;
    localparam int unsigned TIMEOUT = 1000;

    logic       clk;
    logic       rst_n;
    logic       clear;
    logic       flush;
    logic [4:0] count;
    logic       overflow;
    logic [7:0] err_cnt;
    logic       idle;

    uart_rx_buffer_if bus ();

    uart_rx_buffer #(
        .DEPTH          (DEPTH),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .bus        (bus),
        .clear_i    (clear),
        .flush_i    (flush),
        .count_o    (count),
        .overflow_o (overflow),
        .err_cnt_o  (err_cnt),
        .idle_o     (idle)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int vectors     = 0;
    int miscompares = 0;
    bit chk_en      = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    byte unsigned q[$];
    bit           m_ovf   = 1'b0;
    int           m_err   = 0;
    longint       cyc     = 0;
    bit           m_armed = 1'b0;
    longint       m_last  = 0;

    function automatic bit exp_idle();
`ifdef UART_RX_IDLE_TIMEOUT_EN
        return m_armed && (cyc - m_last == longint'(TIMEOUT)) &&
               !bus.rx_ready && !bus.rx_error && !flush;
`else
        return 1'b0;
`endif
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            q.delete();
            m_ovf   = 1'b0;
            m_err   = 0;
            m_armed = 1'b0;
        end else begin
            bit idle_now;
            bit pop;
            bit good;
            int sz;
            idle_now = exp_idle();
            sz   = q.size();
            pop  = (sz != 0) && bus.out_ready;
            good = bus.rx_ready && !bus.rx_error && !flush;
            if (flush) begin
                q.delete();
            end else begin
                if (pop) void'(q.pop_front());
                if (good) begin
                    if (sz < int'(DEPTH) || pop) q.push_back(bus.rx_val);
                end
            end
            if (good && sz == int'(DEPTH) && !pop) m_ovf = 1'b1;
            else if (clear) m_ovf = 1'b0;
            if (bus.rx_error) m_err = clear ? 1 : (m_err < 255 ? m_err + 1 : 255);
            else if (clear) m_err = 0;
            if (flush) m_armed = 1'b0;
            else if (bus.rx_ready || bus.rx_error) begin
                m_armed = 1'b1;
                m_last  = cyc;
            end else if (idle_now) m_armed = 1'b0;
        end
        cyc++;
    end

    // One compare process, sampled just after the falling edge where inputs change.
    always @(negedge clk) begin
        #1;
        if (chk_en) begin
            check("out_valid", bus.out_valid, q.size() != 0);
            if (q.size() != 0) check("out_data", bus.out_data, q[0]);
            check("count", count, q.size());
            check("overflow", overflow, m_ovf);
            check("err_cnt", err_cnt, m_err);
            check("idle", idle, exp_idle());
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit rdy, input bit err, input logic [7:0] val,
                         input bit ordy, input bit fl, input bit clr);
        @(negedge clk);
        bus.rx_ready  = rdy;
        bus.rx_error  = err;
        bus.rx_val    = val;
        bus.out_ready = ordy;
        flush         = fl;
        clear         = clr;
    endtask

    task automatic quiet(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int pulses;
        rst_n         = 1'b0;
        bus.rx_ready  = 1'b0;
        bus.rx_error  = 1'b0;
        bus.rx_val    = 8'h00;
        bus.out_ready = 1'b0;
        flush         = 1'b0;
        clear         = 1'b0;
        repeat (3) @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Reset state
        quiet(1);
        check("reset out_valid", bus.out_valid, 1'b0);
        check("reset count", count, 0);
        check("reset overflow", overflow, 1'b0);
        check("reset err_cnt", err_cnt, 0);

        // Three good frames, consumer stalled, then drained
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 8'h95, 1'b0, 1'b0, 1'b0);
            quiet(20);
        end
        check("three frames count", count, 3);
        check("three frames data", bus.out_data, 8'h95);
        check("three frames err_cnt", err_cnt, 0);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        quiet(1);
        check("drained out_valid", bus.out_valid, 1'b0);

        // Error frame with rx_ready is dropped and counted; saturation; clear
        drive(1'b1, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
        quiet(1);
        check("error frame count", count, 0);
        check("error frame err_cnt", err_cnt, 1);
        for (int i = 0; i < 300; i++) drive(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        quiet(1);
        check("err_cnt saturated", err_cnt, 255);
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        quiet(1);
        check("err_cnt cleared", err_cnt, 0);

        // Overflow: 17 pushes into 16 entries
        for (int i = 0; i <= 16; i++) drive(1'b1, 1'b0, 8'(i), 1'b0, 1'b0, 1'b0);
        quiet(1);
        check("full count", count, 16);
        check("overflow set", overflow, 1'b1);
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            check("overflow pop order", bus.out_data, i);
        end
        quiet(1);
        check("overflow drained", bus.out_valid, 1'b0);
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // Push and pop together while full
        for (int i = 0; i < 16; i++) drive(1'b1, 1'b0, 8'(8'h50 + i), 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 8'hAA, 1'b1, 1'b0, 1'b0);
        quiet(1);
        check("full push+pop count", count, 16);
        check("full push+pop overflow", overflow, 1'b0);
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            if (i == 15) check("0xAA read last", bus.out_data, 8'hAA);
        end
        quiet(1);

        // Pointer wrap over 40 push/pop pairs
        drive(1'b1, 1'b0, 8'h40, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 40; i++) drive(1'b1, 1'b0, 8'(8'h40 + i), 1'b1, 1'b0, 1'b0);
        quiet(1);
        check("wrap head", bus.out_data, 8'h68);
        check("wrap count", count, 1);
        drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Flush with a coincident push
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 8'h77, 1'b0, 1'b1, 1'b0);
        quiet(1);
        check("flush count", count, 0);
        check("flush out_valid", bus.out_valid, 1'b0);
        quiet(2);
        check("flush 0x77 not stored", count, 0);

`ifdef UART_RX_IDLE_TIMEOUT_EN
        // No pulse without traffic; a restrike moves the pulse.
        pulses = 0;
        for (int i = 0; i < 1200; i++) begin
            quiet(1);
            #1 pulses += int'(idle);
        end
        check("no idle without traffic", pulses, 0);
        drive(1'b1, 1'b0, 8'h21, 1'b0, 1'b0, 1'b0);
        #1 pulses += int'(idle);
        for (int i = 1; i < 1700; i++) begin
            if (i == 500) drive(1'b1, 1'b0, 8'h22, 1'b0, 1'b0, 1'b0);
            else quiet(1);
            #1 pulses += int'(idle);
        end
        check("single idle pulse", pulses, 1);
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
`else
        pulses = 0;
        for (int i = 0; i < 50; i++) begin
            quiet(1);
            #1 pulses += int'(idle);
        end
        check("idle tied low", pulses, 0);
`endif

        // Randomized traffic with varying consumer pressure and one mid-burst reset
        for (int i = 0; i < 4000; i++) begin
            int pop_pct;
            bit rdy;
            bit err;
            bit ordy;
            bit fl;
            bit clr;
            pop_pct = ((i / 250) % 4 == 0) ? 0 : ((i / 250) % 4 == 1) ? 25 :
                      ((i / 250) % 4 == 2) ? 75 : 100;
            rdy  = ($urandom_range(99) < 60);
            err  = ($urandom_range(99) < 8);
            ordy = ($urandom_range(99) < pop_pct);
            fl   = ($urandom_range(99) < 2);
            clr  = ($urandom_range(99) < 3);
            drive(rdy, err, 8'($urandom), ordy, fl, clr);
            rst_n = (i != 2000);
        end
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        quiet(3);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
